// File: rtl/ipsxe_floating_point_vmacc_pkg.sv
// Shared constants, width helpers and per-beat flag bundle for the framed
// floating-point multiply-accumulate engine.
package ipsxe_floating_point_vmacc_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_FLOAT_EXP_BIT  = 8;
    localparam int DEF_FLOAT_FRAC_BIT = 24;
    localparam int DEF_FIXED_INT_BIT  = 24;
    localparam int DEF_FIXED_FRAC_BIT = 8;
    localparam int DEF_ACC_GUARD_BIT  = 16;

    // Flags travelling alongside each operand beat.
    typedef struct packed {
        logic last;
        logic ovf;
        logic inv;
    } beat_flags_t;

    function automatic int acc_width(input int data_width, input int guard_bit);
        return 2 * data_width + guard_bit;
    endfunction

    function automatic int exp_bias(input int exp_bit);
        return (1 << (exp_bit - 1)) - 1;
    endfunction

    // Saturation limits are whole numbers, so a saturated value converts to
    // float without further truncation.
    function automatic logic [63:0] fix_max(input int int_bit, input int frac_bit);
        return ((64'd1 << (int_bit - 1 + frac_bit)) - 64'd1) & ~((64'd1 << frac_bit) - 64'd1);
    endfunction

    function automatic logic [63:0] fix_min(input int int_bit, input int frac_bit);
        return ~((64'd1 << (int_bit - 1 + frac_bit)) - 64'd1);
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_vmacc_fl2fx.sv
// Combinational float to signed fixed-point converter: truncates toward zero,
// saturates on range overflow, flags NaN/Inf as invalid.
module ipsxe_floating_point_vmacc_fl2fx
    import ipsxe_floating_point_vmacc_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int FLOAT_EXP_BIT  = DEF_FLOAT_EXP_BIT,
    parameter int FLOAT_FRAC_BIT = DEF_FLOAT_FRAC_BIT,
    parameter int FIXED_INT_BIT  = DEF_FIXED_INT_BIT,
    parameter int FIXED_FRAC_BIT = DEF_FIXED_FRAC_BIT
) (
    input  logic [DATA_WIDTH-1:0] fl_i,
    output logic [DATA_WIDTH-1:0] fx_o,
    output logic                  ovf_o,
    output logic                  inv_o
);

    localparam int MAN_W    = FLOAT_FRAC_BIT - 1;
    localparam int BIAS     = exp_bias(FLOAT_EXP_BIT);
    // Exponent at which the significand integer already equals the fixed code.
    localparam int SHIFT_PT = BIAS + MAN_W - FIXED_FRAC_BIT;
    localparam int SAT_EXP  = BIAS + FIXED_INT_BIT - 1;
    localparam logic [63:0] FIX_MAX_W = fix_max(FIXED_INT_BIT, FIXED_FRAC_BIT);
    localparam logic [63:0] FIX_MIN_W = fix_min(FIXED_INT_BIT, FIXED_FRAC_BIT);
    localparam logic [DATA_WIDTH-1:0] FIX_MAX = FIX_MAX_W[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] FIX_MIN = FIX_MIN_W[DATA_WIDTH-1:0];

    logic                     sign;
    logic [FLOAT_EXP_BIT-1:0] exp_f;
    logic [MAN_W-1:0]         man;
    logic [DATA_WIDTH-1:0]    sig;
    logic [DATA_WIDTH-1:0]    mag;
    int                       exp_i;

    always_comb begin
        sign  = fl_i[DATA_WIDTH-1];
        exp_f = fl_i[DATA_WIDTH-2 -: FLOAT_EXP_BIT];
        man   = fl_i[MAN_W-1:0];
        exp_i = int'(exp_f);
        sig   = DATA_WIDTH'({1'b1, man});
        mag   = '0;
        fx_o  = '0;
        ovf_o = 1'b0;
        inv_o = 1'b0;
        if (&exp_f) begin
            // NaN is treated as positive; only -Inf saturates low.
            inv_o = 1'b1;
            fx_o  = (sign && (man == '0)) ? FIX_MIN : FIX_MAX;
        end else if (exp_f == '0) begin
            fx_o = '0;
        end else if (exp_i >= SAT_EXP) begin
            ovf_o = 1'b1;
            fx_o  = sign ? FIX_MIN : FIX_MAX;
        end else begin
            if (exp_i >= SHIFT_PT)
                mag = sig << (exp_i - SHIFT_PT);
            else
                mag = sig >> (SHIFT_PT - exp_i);
            fx_o = sign ? -mag : mag;
        end
    end

endmodule

// File: rtl/ipsxe_floating_point_vmacc_v2_0.sv
// Framed floating-point dot-product engine: accumulates a*b over one
// AXI4-Stream frame and emits the float sum when tlast retires.
module ipsxe_floating_point_vmacc_v2_0
    import ipsxe_floating_point_vmacc_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int FLOAT_EXP_BIT  = DEF_FLOAT_EXP_BIT,
    parameter int FLOAT_FRAC_BIT = DEF_FLOAT_FRAC_BIT,
    parameter int FIXED_INT_BIT  = DEF_FIXED_INT_BIT,
    parameter int FIXED_FRAC_BIT = DEF_FIXED_FRAC_BIT,
    parameter int ACC_GUARD_BIT  = DEF_ACC_GUARD_BIT
) (
    input  logic                  i_aclk,
    input  logic                  i_areset,
    input  logic                  i_aclken,
    input  logic [DATA_WIDTH-1:0] i_axi4s_a_tdata,
    input  logic [DATA_WIDTH-1:0] i_axi4s_b_tdata,
    input  logic                  i_axi4s_tvalid,
    input  logic                  i_axi4s_tlast,
    output logic                  o_axi4s_tready,
    output logic [DATA_WIDTH-1:0] o_axi4s_result_tdata,
    output logic                  o_axi4s_result_tvalid,
    input  logic                  i_axi4s_result_tready,
    output logic                  o_overflow,
    output logic                  o_invalid_op
);

    localparam int ACC_W    = acc_width(DATA_WIDTH, ACC_GUARD_BIT);
    localparam int PROD_W   = 2 * DATA_WIDTH;
    localparam int EXP_BIAS = exp_bias(FLOAT_EXP_BIT);
    localparam int MAN_W    = FLOAT_FRAC_BIT - 1;
    localparam logic [63:0] FIX_MAX_W = fix_max(FIXED_INT_BIT, FIXED_FRAC_BIT);
    localparam logic [63:0] FIX_MIN_W = fix_min(FIXED_INT_BIT, FIXED_FRAC_BIT);
    localparam logic [DATA_WIDTH-1:0] FIX_MAX = FIX_MAX_W[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] FIX_MIN = FIX_MIN_W[DATA_WIDTH-1:0];

    logic adv;
    assign adv            = i_aclken & ~(o_axi4s_result_tvalid & ~i_axi4s_result_tready);
    assign o_axi4s_tready = adv;

    logic [1:0][DATA_WIDTH-1:0] op_fl;
    logic [1:0][DATA_WIDTH-1:0] op_fx;
    logic [1:0]                 op_ovf;
    logic [1:0]                 op_inv;

    assign op_fl[0] = i_axi4s_a_tdata;
    assign op_fl[1] = i_axi4s_b_tdata;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fl2fx
        ipsxe_floating_point_vmacc_fl2fx #(
            .DATA_WIDTH     (DATA_WIDTH),
            .FLOAT_EXP_BIT  (FLOAT_EXP_BIT),
            .FLOAT_FRAC_BIT (FLOAT_FRAC_BIT),
            .FIXED_INT_BIT  (FIXED_INT_BIT),
            .FIXED_FRAC_BIT (FIXED_FRAC_BIT)
        ) u_fl2fx (
            .fl_i  (op_fl[gi]),
            .fx_o  (op_fx[gi]),
            .ovf_o (op_ovf[gi]),
            .inv_o (op_inv[gi])
        );
    end

    logic                         s1_valid_q;
    logic signed [DATA_WIDTH-1:0] s1_a_q;
    logic signed [DATA_WIDTH-1:0] s1_b_q;
    beat_flags_t                  s1_flags_q;
    logic                         s2_valid_q;
    logic signed [PROD_W-1:0]     s2_prod_q;
    beat_flags_t                  s2_flags_q;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic                         first_q, first_d;
    logic                         ovf_st_q, ovf_st_d;
    logic                         inv_st_q, inv_st_d;
    logic                         s3_valid_q;

    // Accumulator: the first beat of a frame replaces the stale sum.
    always_comb begin
        acc_d    = acc_q;
        ovf_st_d = ovf_st_q;
        inv_st_d = inv_st_q;
        first_d  = first_q;
        if (s2_valid_q) begin
            acc_d    = (first_q ? '0 : acc_q) + ACC_W'(s2_prod_q);
            ovf_st_d = (first_q ? 1'b0 : ovf_st_q) | s2_flags_q.ovf;
            inv_st_d = (first_q ? 1'b0 : inv_st_q) | s2_flags_q.inv;
            first_d  = s2_flags_q.last;
        end
    end

    logic signed [ACC_W-1:0]        acc_sh;
    logic [ACC_W-DATA_WIDTH:0]      acc_hi;
    logic                           fits;
    logic                           sat_d;
    logic [DATA_WIDTH-1:0]          fx_res;
    logic [DATA_WIDTH-1:0]          fx_mag;
    logic                           res_sign;
    logic [FLOAT_EXP_BIT-1:0]       res_exp;
    logic [MAN_W-1:0]               res_man;
    logic [DATA_WIDTH-1:0]          res_d;
    int                             lead;

    // Rescale to the fixed format, saturate, then normalise to float.
    always_comb begin
        acc_sh   = acc_q >>> FIXED_FRAC_BIT;
        acc_hi   = acc_sh[ACC_W-1:DATA_WIDTH-1];
        fits     = (&acc_hi) | ~(|acc_hi);
        sat_d    = ~fits;
        fx_res   = fits ? acc_sh[DATA_WIDTH-1:0] : (acc_hi[ACC_W-DATA_WIDTH] ? FIX_MIN : FIX_MAX);
        res_sign = fx_res[DATA_WIDTH-1];
        fx_mag   = res_sign ? -fx_res : fx_res;
        lead     = 0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (fx_mag[i])
                lead = i;
        end
        if (lead >= MAN_W)
            res_man = MAN_W'(fx_mag >> (lead - MAN_W));
        else
            res_man = MAN_W'(fx_mag << (MAN_W - lead));
        res_exp = FLOAT_EXP_BIT'(lead - FIXED_FRAC_BIT + EXP_BIAS);
        res_d   = (fx_mag == '0) ? '0 : {res_sign, res_exp, res_man};
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            s1_valid_q            <= 1'b0;
            s1_a_q                <= '0;
            s1_b_q                <= '0;
            s1_flags_q            <= '0;
            s2_valid_q            <= 1'b0;
            s2_prod_q             <= '0;
            s2_flags_q            <= '0;
            acc_q                 <= '0;
            first_q               <= 1'b1;
            ovf_st_q              <= 1'b0;
            inv_st_q              <= 1'b0;
            s3_valid_q            <= 1'b0;
            o_axi4s_result_tvalid <= 1'b0;
            o_axi4s_result_tdata  <= '0;
            o_overflow            <= 1'b0;
            o_invalid_op          <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= i_axi4s_tvalid;
            s1_a_q     <= op_fx[0];
            s1_b_q     <= op_fx[1];
            s1_flags_q <= '{last: i_axi4s_tlast, ovf: |op_ovf, inv: |op_inv};
            s2_valid_q <= s1_valid_q;
            s2_prod_q  <= PROD_W'(s1_a_q) * PROD_W'(s1_b_q);
            s2_flags_q <= s1_flags_q;
            acc_q      <= acc_d;
            first_q    <= first_d;
            ovf_st_q   <= ovf_st_d;
            inv_st_q   <= inv_st_d;
            s3_valid_q <= s2_valid_q & s2_flags_q.last;
            // adv implies the previous result is accepted or absent.
            if (s3_valid_q) begin
                o_axi4s_result_tvalid <= 1'b1;
                o_axi4s_result_tdata  <= res_d;
                o_overflow            <= sat_d | ovf_st_q;
                o_invalid_op          <= inv_st_q;
            end else begin
                o_axi4s_result_tvalid <= 1'b0;
            end
        end
    end

endmodule
